// File: rtl/sram_read_arbiter.sv
// Round-robin burst arbiter sharing one read SRAM port between NUM_REQ tile readers.
// Optional per-grant beat limit: define ARB_BURST_LIMIT_EN (limit = MAX_BURST beats).
module sram_read_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned SRAM_WIDTH   = 64,
  parameter int unsigned SRAM_LATENCY = 1,
  parameter int unsigned MAX_BURST    = 16
) (
  input  logic                          i_clk,
  input  logic                          i_nrst,
  input  logic                          i_reg_clear,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_REQ-1:0]            i_req_last,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_sram_read_en,
  output logic [ADDR_WIDTH-1:0]         o_read_addr,
  input  logic [SRAM_WIDTH-1:0]         i_sram_data,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [SRAM_WIDTH-1:0]         o_rsp_data,
  output logic [$clog2(NUM_REQ)-1:0]    o_grant,
  output logic                          o_busy
);

  localparam int unsigned GW         = $clog2(NUM_REQ);
  localparam int unsigned PIPE_DEPTH = SRAM_LATENCY + 1;

  typedef enum logic {ST_IDLE, ST_BURST} state_e;

  state_e                  state_q;
  logic [GW-1:0]           grant_q;
  logic [GW-1:0]           rr_ptr_q;
  logic                    busy_q;
  logic [NUM_REQ-1:0]      req_ready_q;
  logic                    read_en_q;
  logic [ADDR_WIDTH-1:0]   read_addr_q;
  logic [NUM_REQ-1:0]      tag_pipe_q [PIPE_DEPTH];

  logic [GW-1:0]           grant_d;
  logic [GW-1:0]           scan_idx_c;
  logic [GW-1:0]           next_ptr_c;
  logic                    hit_c;
  logic                    accept_c;
  logic                    limit_c;
  logic                    release_c;
  logic [NUM_REQ-1:0]      grant_oh_c;
  logic [NUM_REQ-1:0]      hit_oh_c;
  logic [ADDR_WIDTH-1:0]   req_addr_c [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   beat_addr_c;

  // Round-robin scan; iterating downward lets the smallest offset from rr_ptr win.
  always_comb begin
    hit_c      = 1'b0;
    grant_d    = rr_ptr_q;
    scan_idx_c = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_idx_c = GW'((32'(rr_ptr_q) + 32'(i)) % NUM_REQ);
      if (i_req_valid[scan_idx_c]) begin
        hit_c   = 1'b1;
        grant_d = scan_idx_c;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      req_addr_c[k] = i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  assign beat_addr_c = req_addr_c[grant_q];
  assign grant_oh_c  = NUM_REQ'(1) << grant_q;
  assign hit_oh_c    = NUM_REQ'(1) << grant_d;
  assign next_ptr_c  = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  // ready is only ever one-hot on the grant while in BURST
  assign accept_c    = |(i_req_valid & req_ready_q);
  assign release_c   = accept_c & (i_req_last[grant_q] | limit_c);

`ifdef ARB_BURST_LIMIT_EN
  localparam int unsigned CNT_W = ($clog2(MAX_BURST + 1) > 8) ? $clog2(MAX_BURST + 1) : 8;

  logic [CNT_W-1:0] beat_cnt_q;

  assign limit_c = (beat_cnt_q == CNT_W'(MAX_BURST - 1));

  // Beats accepted under the current grant.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      beat_cnt_q <= '0;
    end else if (i_reg_clear || (state_q == ST_IDLE)) begin
      beat_cnt_q <= '0;
    end else if (accept_c) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign limit_c    = 1'b0;
  assign unused_cfg = (MAX_BURST > 0);
`endif

  // Arbitration FSM, registered SRAM port and tag pipe.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= '0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) tag_pipe_q[s] <= '0;
    end else if (i_reg_clear) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      req_ready_q <= '0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) tag_pipe_q[s] <= '0;
    end else begin
      read_en_q     <= accept_c;
      read_addr_q   <= accept_c ? beat_addr_c : '0;
      tag_pipe_q[0] <= accept_c ? grant_oh_c : '0;
      for (int s = 1; s < PIPE_DEPTH; s++) tag_pipe_q[s] <= tag_pipe_q[s-1];
      case (state_q)
        ST_IDLE: begin
          if (hit_c) begin
            state_q     <= ST_BURST;
            grant_q     <= grant_d;
            req_ready_q <= hit_oh_c;
            busy_q      <= 1'b1;
          end
        end
        ST_BURST: begin
          if (release_c) begin
            state_q     <= ST_IDLE;
            req_ready_q <= '0;
            busy_q      <= 1'b0;
            rr_ptr_q    <= next_ptr_c;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ready    = req_ready_q;
  assign o_sram_read_en = read_en_q;
  assign o_read_addr    = read_addr_q;
  assign o_rsp_valid    = tag_pipe_q[PIPE_DEPTH-1];
  assign o_rsp_data     = i_sram_data;
  assign o_grant        = grant_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Randomized scoreboard bench for sram_read_arbiter against a transaction-level arbitration model.
`timescale 1ns/1ps
module tb_sram_read_arbiter;

  localparam int unsigned NREQ = 2;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 64;
  localparam int unsigned LAT  = 1;
  localparam int unsigned MAXB = 4;
`ifdef ARB_BURST_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 nrst;
  logic                 clr;
  logic [NREQ-1:0]      valid;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ-1:0]      last;
  logic [DW-1:0]        sdata;
  logic [NREQ-1:0]      o_req_ready;
  logic                 o_sram_read_en;
  logic [AW-1:0]        o_read_addr;
  logic [NREQ-1:0]      o_rsp_valid;
  logic [DW-1:0]        o_rsp_data;
  logic [$clog2(NREQ)-1:0] o_grant;
  logic                 o_busy;

  always #5 clk = ~clk;

  sram_read_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .SRAM_WIDTH(DW), .SRAM_LATENCY(LAT), .MAX_BURST(MAXB)
  ) dut (
    .i_clk(clk), .i_nrst(nrst), .i_reg_clear(clr),
    .i_req_valid(valid), .i_req_addr(addr), .i_req_last(last), .o_req_ready(o_req_ready),
    .o_sram_read_en(o_sram_read_en), .o_read_addr(o_read_addr), .i_sram_data(sdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_grant(o_grant), .o_busy(o_busy)
  );

  typedef struct packed { logic [AW-1:0] addr; logic last; } beat_t;
  typedef struct packed { int req; logic [AW-1:0] addr; int due; } rsp_t;

  beat_t         beats [NREQ][64];
  int            head  [NREQ];
  int            tail  [NREQ];
  logic [AW-1:0] exp_issue [$];
  rsp_t          exp_rsp   [$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            clr_once = 1'b0;
  int            m_owner = -1;
  int            m_rr = 0;
  int            m_cnt = 0;
  logic [DW-1:0] dp [LAT];

  function automatic logic [63:0] hash(input logic [7:0] a);
    return {a, ~a, a ^ 8'h3C, a + 8'd1, 8'hA5, a, ~a, a ^ 8'hC3};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic load_burst(input int k, input int len, input logic [AW-1:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      beats[k][i].addr = rnd ? AW'($urandom) : base + AW'(i);
      beats[k][i].last = (i == len - 1);
    end
    head[k] = 0;
    tail[k] = len;
  endtask

  // One bus cycle: record accepted beats, then drive the next cycle's requests.
  task automatic run_cycle(input int stall_pct, input int gen_pct, input int min_len,
                           input int max_len, input int clr_pm);
    logic [NREQ-1:0] acc;
    logic            clr_s;
    beat_t           b;
    @(negedge clk);
    acc   = valid & o_req_ready & {NREQ{~clr}};
    clr_s = clr;
    @(posedge clk);
    #1;
    if (clr_s) begin
      exp_issue.delete();
      exp_rsp.delete();
    end
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k] && head[k] < tail[k]) begin
        b = beats[k][head[k]];
        exp_issue.push_back(b.addr);
        exp_rsp.push_back('{req: k, addr: b.addr, due: cyc + int'(LAT)});
        head[k]++;
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (head[k] >= tail[k] && $urandom_range(0, 99) < gen_pct)
        load_burst(k, int'($urandom_range(min_len, max_len)), '0, 1'b1);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (head[k] < tail[k]) begin
        valid[k]            = ($urandom_range(0, 99) >= stall_pct);
        addr[k*AW +: AW]    = beats[k][head[k]].addr;
        last[k]             = beats[k][head[k]].last;
      end else begin
        valid[k]            = 1'b0;
        addr[k*AW +: AW]    = AW'($urandom);
        last[k]             = 1'($urandom_range(0, 1));
      end
    end
    clr = ($urandom_range(0, 999) < clr_pm);
    if (clr_once && exp_issue.size() > 0) begin
      clr      = 1'b1;
      clr_once = 1'b0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM macro model: data for an issued address appears LAT cycles later.
  initial begin
    logic          cap_en;
    logic [AW-1:0] cap_addr;
    sdata = '0;
    for (int j = 0; j < LAT; j++) dp[j] = '0;
    forever begin
      @(negedge clk);
      cap_en   = o_sram_read_en;
      cap_addr = o_read_addr;
      @(posedge clk);
      #1;
      for (int j = LAT - 1; j > 0; j--) dp[j] = dp[j-1];
      dp[0] = cap_en ? hash(cap_addr) : {$urandom, $urandom};
      sdata = dp[LAT-1];
    end
  end

  // Monitor: compare DUT against the model's grant owner and the expected-read queues.
  initial begin
    rsp_t          r;
    logic [AW-1:0] a;
    bit            found;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("busy", 64'(o_busy), 64'(m_owner >= 0));
        if (m_owner >= 0) chk("grant", 64'(o_grant), 64'(m_owner));
        chk("ready", 64'(o_req_ready), (m_owner >= 0) ? (64'(1) << m_owner) : 64'(0));
        if (exp_issue.size() > 0) begin
          a = exp_issue.pop_front();
          chk("issue_en", 64'(o_sram_read_en), 64'(1));
          chk("issue_addr", 64'(o_read_addr), 64'(a));
        end else begin
          chk("idle_en", 64'(o_sram_read_en), 64'(0));
          chk("idle_addr", 64'(o_read_addr), 64'(0));
        end
        if (exp_rsp.size() > 0 && exp_rsp[0].due == cyc) begin
          r = exp_rsp.pop_front();
          chk("rsp_valid", 64'(o_rsp_valid), 64'(1) << r.req);
          chk("rsp_data", o_rsp_data, hash(r.addr));
        end else begin
          chk("rsp_none", 64'(o_rsp_valid), 64'(0));
        end
        if (clr) begin
          m_owner = -1;
          m_rr    = 0;
        end else if (m_owner < 0) begin
          found = 1'b0;
          for (int i = 0; i < NREQ; i++) begin
            if (!found && valid[(m_rr + i) % NREQ]) begin
              found   = 1'b1;
              m_owner = (m_rr + i) % NREQ;
              m_cnt   = 0;
            end
          end
        end else if (valid[m_owner]) begin
          m_cnt++;
          if (last[m_owner] || (LIMIT && m_cnt == int'(MAXB))) begin
            m_rr    = (m_owner + 1) % NREQ;
            m_owner = -1;
          end
        end
      end
    end
  end

  initial begin
    nrst = 1'b0; clr = 1'b0; valid = '0; last = '0; addr = '0;
    for (int k = 0; k < NREQ; k++) begin head[k] = 0; tail[k] = 0; end

    // reset held while inputs toggle
    repeat (6) begin
      @(posedge clk);
      #1;
      valid = NREQ'($urandom); last = NREQ'($urandom); addr = (NREQ*AW)'($urandom);
      clr = 1'($urandom);
      @(negedge clk);
      chk("rst_ready", 64'(o_req_ready), 64'(0));
      chk("rst_en", 64'(o_sram_read_en), 64'(0));
      chk("rst_addr", 64'(o_read_addr), 64'(0));
      chk("rst_rsp", 64'(o_rsp_valid), 64'(0));
      chk("rst_grant", 64'(o_grant), 64'(0));
      chk("rst_busy", 64'(o_busy), 64'(0));
    end
    @(posedge clk);
    #1;
    valid = '0; last = '0; clr = 1'b0; nrst = 1'b1; mon_en = 1'b1;
    repeat (4) run_cycle(0, 0, 1, 1, 0);

    // single requester burst 0x10..0x13
    load_burst(0, 4, 8'h10, 1'b0);
    repeat (12) run_cycle(0, 0, 1, 1, 0);

    // both requesters with back-to-back 2-beat bursts
    repeat (30) run_cycle(0, 100, 2, 2, 0);
    repeat (20) run_cycle(0, 0, 1, 1, 0);

    // clear right as a beat issues; next grant must restart at req0
    load_burst(0, 4, 8'h40, 1'b0);
    load_burst(1, 4, 8'h80, 1'b0);
    clr_once = 1'b1;
    repeat (30) run_cycle(0, 0, 1, 1, 0);

    // long random run with stalls and occasional clears
    repeat (3000) run_cycle(25, 30, 1, 6, 8);
    repeat (40) run_cycle(0, 0, 1, 1, 0);
    chk("drain_issue", 64'(exp_issue.size()), 64'(0));
    chk("drain_rsp", 64'(exp_rsp.size()), 64'(0));

    // async reset mid-burst
    load_burst(1, 8, 8'hC0, 1'b0);
    repeat (4) run_cycle(0, 0, 1, 1, 0);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    nrst   = 1'b0;
    #1;
    chk("arst_busy", 64'(o_busy), 64'(0));
    chk("arst_ready", 64'(o_req_ready), 64'(0));
    chk("arst_en", 64'(o_sram_read_en), 64'(0));
    chk("arst_rsp", 64'(o_rsp_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
